// File: rtl/window_3x3_pkg.sv
// Shared types and helpers for the 3x3 window former: the default pixel type
// and the counter-width rule used for the column/row position counters.
package window_3x3_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] pix_t;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_3x3_col_shift.sv
// Three-stage pixel shift register with enable; q0 is the oldest column (x-2),
// q2 the newest (x).
module window_col_shift #(
  parameter int unsigned DATA_WIDTH = window_3x3_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q0,
  output logic [DATA_WIDTH-1:0] o_q1,
  output logic [DATA_WIDTH-1:0] o_q2
);

  logic [DATA_WIDTH-1:0] r_q0, r_q1, r_q2;

  // NOTE: reset is sampled on the clock edge like any other input, so it lives
  // inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q0 <= '0;
      r_q1 <= '0;
      r_q2 <= '0;
    end else if (i_en) begin
      r_q0 <= r_q1;
      r_q1 <= r_q2;
      r_q2 <= i_d;
    end
  end

  assign o_q0 = r_q0;
  assign o_q1 = r_q1;
  assign o_q2 = r_q2;

endmodule

// File: rtl/window_3x3.sv
// 3x3 sliding window after the line buffer: shifts in one vertical 3-pixel
// column per accepted beat and flags windows fully inside the frame.
module window_3x3
  import window_3x3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] pix_curr,
  input  logic [DATA_WIDTH-1:0] pix_m1,
  input  logic [DATA_WIDTH-1:0] pix_m2,
  output logic                  win_valid,
  output logic [DATA_WIDTH-1:0] p00,
  output logic [DATA_WIDTH-1:0] p01,
  output logic [DATA_WIDTH-1:0] p02,
  output logic [DATA_WIDTH-1:0] p10,
  output logic [DATA_WIDTH-1:0] p11,
  output logic [DATA_WIDTH-1:0] p12,
  output logic [DATA_WIDTH-1:0] p20,
  output logic [DATA_WIDTH-1:0] p21,
  output logic [DATA_WIDTH-1:0] p22
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned RW = cnt_width(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] r_col_cnt;
  logic [RW-1:0] r_row_cnt;
  logic          r_win_valid;
  logic          w_in_frame;

  window_col_shift #(.DATA_WIDTH(DATA_WIDTH)) u_row_top (
    .clk(clk), .rst_n(rst_n), .i_en(in_valid), .i_d(pix_m2),
    .o_q0(p00), .o_q1(p01), .o_q2(p02)
  );

  window_col_shift #(.DATA_WIDTH(DATA_WIDTH)) u_row_mid (
    .clk(clk), .rst_n(rst_n), .i_en(in_valid), .i_d(pix_m1),
    .o_q0(p10), .o_q1(p11), .o_q2(p12)
  );

  window_col_shift #(.DATA_WIDTH(DATA_WIDTH)) u_row_bot (
    .clk(clk), .rst_n(rst_n), .i_en(in_valid), .i_d(pix_curr),
    .o_q0(p20), .o_q1(p21), .o_q2(p22)
  );

  // Judged on the position of the beat being accepted, before the counters move.
  assign w_in_frame = (r_col_cnt >= CW'(2)) && (r_row_cnt >= RW'(2));

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge counter values, matching the shift registers above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_win_valid <= 1'b0;
    end else if (in_valid) begin
      r_win_valid <= w_in_frame;
      if (r_col_cnt == COL_LAST) begin
        r_col_cnt <= '0;
        r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + RW'(1);
      end else begin
        r_col_cnt <= r_col_cnt + CW'(1);
      end
    end else begin
      r_win_valid <= 1'b0;
    end
  end

  assign win_valid = r_win_valid;

endmodule

// File: tb/tb_window_3x3.sv
// Bench for window_3x3 (10x8 frame): hand-written vector table for the first
// window and stall, plus randomized streaming against a column-history model.
module tb_window_3x3;
  import window_3x3_pkg::*;

  localparam int W = 10;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  pix_t pix_curr, pix_m1, pix_m2;
  logic win_valid;
  pix_t p00, p01, p02, p10, p11, p12, p20, p21, p22;
  pix_t dut_taps [9];

  window_3x3 #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .pix_curr(pix_curr), .pix_m1(pix_m1), .pix_m2(pix_m2),
    .win_valid(win_valid),
    .p00(p00), .p01(p01), .p02(p02),
    .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_taps[0] = p00; dut_taps[1] = p01; dut_taps[2] = p02;
    dut_taps[3] = p10; dut_taps[4] = p11; dut_taps[5] = p12;
    dut_taps[6] = p20; dut_taps[7] = p21; dut_taps[8] = p22;
  end

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the last three accepted columns (index 0 oldest) and the
  // linear beat position within the frame.
  pix_t m_col [3][3];
  int   m_pos;
  logic m_valid;

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) m_col[c][r] = '0;
    m_pos   = 0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic v, input pix_t m2, input pix_t m1, input pix_t cu);
    int x, y;
    if (!v) begin
      m_valid = 1'b0;
      return;
    end
    x = m_pos % W;
    y = m_pos / W;
    m_valid = (x >= 2) && (y >= 2);
    m_col[0] = m_col[1];
    m_col[1] = m_col[2];
    m_col[2][0] = m2;
    m_col[2][1] = m1;
    m_col[2][2] = cu;
    m_pos = (m_pos + 1) % (W * H);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".win_valid"}, int'(win_valid), int'(m_valid));
    for (int k = 0; k < 9; k++)
      check($sformatf("%s.p%0d%0d", tag, k / 3, k % 3),
            int'(dut_taps[k]), int'(m_col[k % 3][k / 3]));
  endtask

  task automatic step(input logic v, input pix_t m2, input pix_t m1, input pix_t cu,
                      input string tag);
    in_valid = v;
    pix_m2   = m2;
    pix_m1   = m1;
    pix_curr = cu;
    @(posedge clk);
    #1;
    model_step(v, m2, m1, cu);
    compare_model(tag);
    if (win_valid) pulse_cnt++;
  endtask

  task automatic rand_step(input int idle_pct, input string tag);
    logic v;
    v = ($urandom_range(99) >= idle_pct);
    step(v, pix_t'($urandom), pix_t'($urandom), pix_t'($urandom), tag);
  endtask

  task automatic rand_beat(input string tag);
    step(1'b1, pix_t'($urandom), pix_t'($urandom), pix_t'($urandom), tag);
  endtask

  typedef struct {
    logic v;
    int   reps;
    pix_t m2, m1, cu;
    logic exp_valid;
    logic chk_taps;
    pix_t exp [9];
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int budget;

    // Row 2 of the frame, columns 0..3, then a 5-cycle stall and a resume.
    vecs[0] = '{v:1, reps:1, m2:1,   m1:2,   cu:3,   exp_valid:0, chk_taps:0, exp:'{default:0}};
    vecs[1] = '{v:1, reps:1, m2:4,   m1:5,   cu:6,   exp_valid:0, chk_taps:0, exp:'{default:0}};
    vecs[2] = '{v:1, reps:1, m2:7,   m1:8,   cu:9,   exp_valid:1, chk_taps:1, exp:'{1,4,7,2,5,8,3,6,9}};
    vecs[3] = '{v:1, reps:1, m2:10,  m1:11,  cu:12,  exp_valid:1, chk_taps:1, exp:'{4,7,10,5,8,11,6,9,12}};
    vecs[4] = '{v:0, reps:5, m2:55,  m1:66,  cu:77,  exp_valid:0, chk_taps:1, exp:'{4,7,10,5,8,11,6,9,12}};
    vecs[5] = '{v:1, reps:1, m2:100, m1:101, cu:102, exp_valid:1, chk_taps:1, exp:'{7,10,100,8,11,101,9,12,102}};

    rst_n = 1'b0; in_valid = 1'b1;
    pix_m2 = 8'hAA; pix_m1 = 8'hBB; pix_curr = 8'hCC;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h11, 8'h22, 8'h33, "idle_after_reset");

    // Rows 0 and 1: no window may be flagged.
    for (int i = 0; i < 2 * W; i++) begin
      rand_beat("fill");
      check("fill.no_valid", int'(win_valid), 0);
    end

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].v, vecs[i].m2, vecs[i].m1, vecs[i].cu, $sformatf("vec%0d", i));
        check($sformatf("vec%0d.valid", i), int'(win_valid), int'(vecs[i].exp_valid));
        if (vecs[i].chk_taps)
          for (int k = 0; k < 9; k++)
            check($sformatf("vec%0d.tap%0d", i, k), int'(dut_taps[k]), int'(vecs[i].exp[k]));
      end
    end

    // Finish the current frame with random stalls, then count one full frame.
    budget = 4 * W * H;
    while (m_pos != 0 && budget > 0) begin
      rand_step(25, "to_frame_end");
      budget--;
    end
    check("reach_frame_start", int'(m_pos == 0), 1);
    pulse_cnt = 0;
    budget = 4 * W * H;
    for (int b = 0; b < W * H && budget > 0; ) begin
      rand_step(25, "full_frame");
      if (in_valid) b++;
      budget--;
    end
    check("frame_pulses", pulse_cnt, (W - 2) * (H - 2));

    // Row 0 of the following frame.
    for (int i = 0; i < W; i++) begin
      rand_beat("next_frame_row0");
      check("next_frame_row0.no_valid", int'(win_valid), 0);
    end

    // Move into mid row 3, then reset while beats are still offered.
    while (m_pos != 3 * W + 4) rand_beat("to_mid_row3");
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_model("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W + 3; i++) begin
      rand_beat("after_reset");
      check($sformatf("after_reset.beat%0d", i), int'(win_valid), (i == 2 * W + 2) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/window_3x3.md
Name: window_3x3

Overview:
- Forms a 3x3 pixel window for CNN/convolution pipelines.
- Sits directly after the line-buffer stage, which supplies three vertically aligned pixels per cycle: rows y-2, y-1 and y.
- Shifts those columns into a 3-column register array and exposes all nine taps.
- Tracks column/row position within a WIDTH x HEIGHT frame so win_valid flags only windows that are fully populated with real image data.

Parameters:
- DATA_WIDTH, 8: bits per pixel.
- WIDTH, 640: pixels per image row; minimum 3.
- HEIGHT, 480: rows per frame; minimum 3.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  qualifies pix_curr/pix_m1/pix_m2 this cycle.
- pix_curr  input  DATA_WIDTH  pixel of current row y, column x.
- pix_m1  input  DATA_WIDTH  pixel of row y-1, column x.
- pix_m2  input  DATA_WIDTH  pixel of row y-2, column x.
- win_valid  output  1  window taps hold a complete in-frame 3x3 window.
- p00, p01, p02  output  DATA_WIDTH each  top row (y-2), columns x-2, x-1, x.
- p10, p11, p12  output  DATA_WIDTH each  middle row (y-1), columns x-2, x-1, x.
- p20, p21, p22  output  DATA_WIDTH each  bottom row (y), columns x-2, x-1, x.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low on rst_n.
  - While rst_n=0 at a clock edge: all nine taps, win_valid, col_cnt and row_cnt are cleared to 0.
- Accepted beat (rising edge with in_valid=1):
  - Shift left: p00<=p01, p01<=p02, p02<=pix_m2.
  - Likewise p10<=p11, p11<=p12, p12<=pix_m1.
  - Likewise p20<=p21, p21<=p22, p22<=pix_curr.
  - win_valid <= (col_cnt >= 2) && (row_cnt >= 2), evaluated on pre-increment counter values.
  - col_cnt increments. At WIDTH-1 it wraps to 0 and row_cnt increments.
  - row_cnt wraps from HEIGHT-1 to 0 when col_cnt also wraps (end of frame).
- Idle cycle (in_valid=0):
  - Taps and counters hold.
  - win_valid <= 0.
  - Stalls are therefore transparent: the window resumes exactly where it stopped.
- Latency: one clock. The window containing input column x is visible, with win_valid=1, the cycle after that column is accepted.
- Row boundaries:
  - Columns 0 and 1 of each row produce win_valid=0, so stale columns from the previous row are never flagged valid.
  - The taps still shift and contain mixed-row data during these columns.
- Frame boundaries:
  - Rows 0 and 1 of each frame never assert win_valid, because the y-2/y-1 inputs are undefined there.
  - Per frame, win_valid pulses (WIDTH-2)*(HEIGHT-2) times.
- No padding is generated. Border handling is the downstream consumer's job.
- Reset mid-frame: the next accepted beat is treated as row 0, column 0.
- Counter widths: $clog2(WIDTH) and $clog2(HEIGHT), minimum 1 bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds the pixel type (logic [DATA_WIDTH-1:0]) and a helper function for the counter width.
- One natural sub-module: window_col_shift, a 3-stage DATA_WIDTH shift register with enable. Instantiate it three times, one per row.
- The counters and win_valid logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks -> win_valid=0 and all taps = 0. With in_valid=0 afterwards, everything stays 0.
- Fill gating (WIDTH=10, HEIGHT=8): stream rows 0 and 1 (20 beats) -> win_valid stays 0 throughout.
- First window, row 2: beats (m2,m1,curr) = (1,2,3), (4,5,6), (7,8,9).
  - win_valid=0 after the first two beats.
  - The cycle after the third beat: win_valid=1, p00..p02=1,4,7; p10..p12=2,5,8; p20..p22=3,6,9.
  - Next beat (10,11,12) -> p00..p02=4,7,10; p20..p22=6,9,12; win_valid=1.
- Stall: drop in_valid for 5 cycles mid-row -> win_valid=0 and taps frozen. Resuming with (100,101,102) -> win_valid=1 on the next cycle, p02=100, p12=101, p22=102, p01/p11/p21 = the pre-stall newest column.
- Row wrap: across the column 9 -> column 0 boundary -> win_valid=0 for columns 0 and 1 of the new row, 1 from column 2. Total pulses per full frame = 8*6 = 48.
- Frame wrap and mid-frame reset: after 80 beats, row 0 of the next frame gives no win_valid. Asserting rst_n=0 mid-row, then restarting -> valid again only at row 2, column 2.
